// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the fetch PC, drives program-memory addresses and
// presents the decode-slot instruction to jump control. Redirects squash the
// wrong-path slot; stalls freeze the PCs and buffer the decode instruction.
//
// state  | meaning
// BOOT   | after reset, no instruction fetched yet (bubble)
// RUN    | decode slot is the memory read data of the previous cycle
// HOLD   | stalled, decode slot is the buffered instruction in hold_reg
// SQUASH | redirect taken, slot being read is wrong-path (bubble)
module instruction_fetch_stage #(
  parameter int unsigned           ADDR_W    = 16,
  parameter int unsigned           INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0]    NOP_INSTR = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               pc_mux_sel,
  input  logic [ADDR_W-1:0]  jmp_loc,
  input  logic [INSTR_W-1:0] pm_data,
  output logic [ADDR_W-1:0]  pm_addr,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  current_address,
  output logic [5:0]         op,
  output logic [ADDR_W-1:0]  jmp_address_pm
);

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] SQUASH = 2'd3;

  logic [ADDR_W-1:0]  pc_f;
  logic [ADDR_W-1:0]  pc_d;
  logic [INSTR_W-1:0] hold_reg;
  logic [1:0]         state;

  // PC, decode-PC, hold buffer and slot state; stall freezes the PCs and
  // masks redirects, reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f     <= RESET_PC;
      pc_d     <= RESET_PC;
      hold_reg <= NOP_INSTR;
      state    <= BOOT;
    end else if (stall) begin
      // Only a live RUN slot needs capturing; the read data moves on next
      // cycle because the address was already one ahead.
      if (state == RUN) begin
        hold_reg <= pm_data;
        state    <= HOLD;
      end
    end else if (pc_mux_sel) begin
      pc_f  <= jmp_loc;
      pc_d  <= pc_f;
      state <= SQUASH;
    end else begin
      pc_f  <= pc_f + ADDR_W'(1);
      pc_d  <= pc_f;
      state <= RUN;
    end
  end

  // Decode-slot mux: bubbles present NOP so op decodes as no jump/ret.
  always_comb begin
    instr_out   = NOP_INSTR;
    instr_valid = 1'b0;
    case (state)
      RUN: begin
        instr_out   = pm_data;
        instr_valid = 1'b1;
      end
      HOLD: begin
        instr_out   = hold_reg;
        instr_valid = 1'b1;
      end
      default: begin
        instr_out   = NOP_INSTR;
        instr_valid = 1'b0;
      end
    endcase
  end

  assign pm_addr         = pc_f;
  assign current_address = pc_d;
  assign op              = instr_out[INSTR_W-1 -: 6];
  assign jmp_address_pm  = instr_out[ADDR_W-1:0];

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a slot-level reference model of the fetch stream.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        pc_mux_sel = 1'b0;
  logic [15:0] jmp_loc = 16'h0;
  logic [31:0] pm_data = 32'h0;
  logic [15:0] pm_addr;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [15:0] current_address;
  logic [5:0]  op;
  logic [15:0] jmp_address_pm;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: next address to fetch and the slot seen by decode.
  logic [15:0] m_pc;
  logic [15:0] m_addr;
  logic        m_valid;
  bit          model_ok = 1'b0;

  instruction_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_mux_sel(pc_mux_sel),
    .jmp_loc(jmp_loc), .pm_data(pm_data), .pm_addr(pm_addr),
    .instr_out(instr_out), .instr_valid(instr_valid),
    .current_address(current_address), .op(op),
    .jmp_address_pm(jmp_address_pm)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [15:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  // Synchronous-read program memory.
  always @(posedge clk) pm_data <= memf(pm_addr);

  // Model update: a non-stalled edge either starts a real slot at the fetch
  // address or, on redirect, a wrong-path bubble.
  always @(posedge clk) begin
    if (reset) begin
      m_pc = 16'h0000; m_addr = 16'h0000; m_valid = 1'b0; model_ok = 1'b1;
    end else if (!stall) begin
      m_addr  = m_pc;
      m_valid = !pc_mux_sel;
      m_pc    = pc_mux_sel ? jmp_loc : m_pc + 16'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      logic [31:0] ei;
      ei = m_valid ? memf(m_addr) : 32'h0;
      check("pm_addr", {16'h0, pm_addr}, {16'h0, m_pc});
      check("current_address", {16'h0, current_address}, {16'h0, m_addr});
      check("instr_valid", {31'h0, instr_valid}, {31'h0, m_valid});
      check("instr_out", instr_out, ei);
      check("op", {26'h0, op}, {26'h0, ei[31:26]});
      check("jmp_address_pm", {16'h0, jmp_address_pm}, {16'h0, ei[15:0]});
    end
  end

  task automatic tick(input logic r, input logic s, input logic sel, input logic [15:0] jl);
    reset = r; stall = s; pc_mux_sel = sel; jmp_loc = jl;
    @(negedge clk);
  endtask

  initial begin
    // Reset
    tick(1, 0, 0, 16'h0);
    tick(1, 1, 1, 16'h1234);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_pm_addr", {16'h0, pm_addr}, 32'h0);
    check("rst_instr", instr_out, 32'h0);
    // Run from 0
    tick(0, 0, 0, 16'h0);
    check("run0_addr", {16'h0, current_address}, 32'h0);
    check("run0_pm_addr", {16'h0, pm_addr}, 32'h1);
    check("run0_instr", instr_out, 32'hC3A5_0000);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 16'h0);
    check("run5_addr", {16'h0, current_address}, 32'h5);
    // Jump to 0040
    tick(0, 0, 1, 16'h0040);
    check("jmp_bubble_valid", {31'h0, instr_valid}, 32'h0);
    check("jmp_bubble_instr", instr_out, 32'h0);
    tick(0, 0, 0, 16'h0);
    check("jmp_target_addr", {16'h0, current_address}, 32'h0040);
    check("jmp_target_instr", instr_out, 32'hC3E5_0040);
    // Stall with decode slot at 0010
    tick(0, 0, 1, 16'h0010);
    tick(0, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 16'h0);
      check("stall_instr", instr_out, 32'hC3B5_0010);
      check("stall_pm_addr", {16'h0, pm_addr}, 32'h0011);
    end
    tick(0, 0, 0, 16'h0);
    check("release_addr1", {16'h0, current_address}, 32'h0011);
    tick(0, 0, 0, 16'h0);
    check("release_addr2", {16'h0, current_address}, 32'h0012);
    check("release_instr2", instr_out, 32'hC3B7_0012);
    // Stall masks redirect
    tick(0, 1, 1, 16'h0080);
    tick(0, 1, 1, 16'h0080);
    check("stallsel_addr", {16'h0, current_address}, 32'h0012);
    check("stallsel_pm_addr", {16'h0, pm_addr}, 32'h0013);
    tick(0, 0, 1, 16'h0080);
    check("stallsel_bubble", {31'h0, instr_valid}, 32'h0);
    tick(0, 0, 0, 16'h0);
    check("stallsel_target", {16'h0, current_address}, 32'h0080);
    // Interrupt redirect inside the squash bubble
    tick(0, 0, 1, 16'h0100);
    tick(0, 0, 1, 16'hF000);
    check("irq_bubble2", {31'h0, instr_valid}, 32'h0);
    tick(0, 0, 0, 16'h0);
    check("irq_target", {16'h0, current_address}, 32'hF000);
    check("irq_valid", {31'h0, instr_valid}, 32'h1);
    // Wrap
    tick(0, 0, 1, 16'hFFFE);
    tick(0, 0, 0, 16'h0);
    check("wrap_fffe", {16'h0, current_address}, 32'hFFFE);
    tick(0, 0, 0, 16'h0);
    check("wrap_ffff", {16'h0, current_address}, 32'hFFFF);
    tick(0, 0, 0, 16'h0);
    check("wrap_0000", {16'h0, current_address}, 32'h0000);
    check("wrap_instr", instr_out, 32'hC3A5_0000);
    // Reset during HOLD
    tick(0, 1, 0, 16'h0);
    tick(1, 1, 1, 16'h0055);
    check("midrst_valid", {31'h0, instr_valid}, 32'h0);
    check("midrst_pm_addr", {16'h0, pm_addr}, 32'h0);
    tick(0, 0, 0, 16'h0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, s, sel;
      logic [15:0] jl;
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 25);
      sel = ($urandom_range(0, 99) < 15);
      jl  = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                        : 16'($urandom);
      tick(r, s, sel, jl);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
